unidad_acceso_memoria: RTL and testbench

UNIDAD_ACCESO_MEMORIA -- requirements
Module: Unidad_acceso_memoria

---
 rtl/unidad_acceso_memoria_pkg.sv | 45 ++++
 rtl/unidad_acceso_memoria_alineador_bytes.sv | 55 +++++
 rtl/unidad_acceso_memoria.sv | 126 ++++++++++++
 tb/tb_unidad_acceso_memoria.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unidad_acceso_memoria_pkg.sv
// Shared definitions for the memory access unit: size codes, fault causes,
// FSM state encoding, default memory depth and the acceptance-time fault rule.
package unidad_acceso_memoria_pkg;

    localparam int unsigned MEM_WORDS_DEF = 32;

    // Op size codes
    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;

    // Fault causes reported with Done
    localparam logic [1:0] FAULT_NONE       = 2'b00;
    localparam logic [1:0] FAULT_MISALIGNED = 2'b01;
    localparam logic [1:0] FAULT_RANGE      = 2'b10;
    localparam logic [1:0] FAULT_ILLEGAL    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_MERGE  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Fault cause of a request; illegal Op outranks misalignment, which
    // outranks an out-of-range word index.
    function automatic logic [1:0] fault_of(input logic [2:0]  op,
                                            input logic [31:0] addr,
                                            input int unsigned words);
        logic [31:0] word_idx;
        logic        is_half;
        word_idx = {2'b00, addr[31:2]};
        is_half  = (op == OP_LH) || (op == OP_LHU);
        if (!(op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU}))
            return FAULT_ILLEGAL;
        if ((is_half && addr[0]) || ((op == OP_LW) && (addr[1:0] != 2'b00)))
            return FAULT_MISALIGNED;
        if (word_idx >= words)
            return FAULT_RANGE;
        return FAULT_NONE;
    endfunction

endpackage

// File: rtl/unidad_acceso_memoria_alineador_bytes.sv
// Combinational lane logic: extracts and extends a load from the addressed
// little-endian lanes, and merges store data into a previously read word.
module Alineador_bytes
    import unidad_acceso_memoria_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_store_data,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);
    logic [4:0]  w_shamt;
    logic [31:0] w_shifted;
    logic [31:0] w_mask;
    logic [31:0] w_ins;

    assign w_shamt   = {i_lane, 3'b000};
    assign w_shifted = i_rdata >> w_shamt;

    // Load result: addressed lanes moved to bit 0 and extended by size code
    always_comb begin
        o_load = i_rdata;
        case (i_op)
            OP_LB:   o_load = {{24{w_shifted[7]}},  w_shifted[7:0]};
            OP_LH:   o_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            OP_LBU:  o_load = {24'b0, w_shifted[7:0]};
            OP_LHU:  o_load = {16'b0, w_shifted[15:0]};
            default: o_load = i_rdata;
        endcase
    end

    // Store merge: only the addressed lanes take the new data
    always_comb begin
        w_mask = 32'hFFFF_FFFF;
        w_ins  = i_store_data;
        case (i_op[1:0])
            2'b00: begin
                w_mask = 32'h0000_00FF << w_shamt;
                w_ins  = {24'b0, i_store_data[7:0]} << w_shamt;
            end
            2'b01: begin
                w_mask = 32'h0000_FFFF << w_shamt;
                w_ins  = {16'b0, i_store_data[15:0]} << w_shamt;
            end
            default: begin
                w_mask = 32'hFFFF_FFFF;
                w_ins  = i_store_data;
            end
        endcase
        o_merged = (i_old_word & ~w_mask) | (w_ins & w_mask);
    end

endmodule

// File: rtl/unidad_acceso_memoria.sv
// Memory access unit for the MEM stage: accepts one load/store at a time,
// checks faults at acceptance, drives a word-indexed memory and performs
// read-modify-write for byte and half stores.
module unidad_acceso_memoria
    import unidad_acceso_memoria_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        Is_store,
    input  logic [2:0]  Op,
    input  logic [31:0] Adress,
    input  logic [31:0] Store_data,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Load_data,
    output logic [1:0]  Fault,
    output logic [31:0] Mem_adress,
    output logic [31:0] Mem_write_data,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [31:0] Mem_read_data
);
    state_t      r_state;
    state_t      w_next;
    logic [6:0]  r_addr;
    logic [2:0]  r_op;
    logic        r_store;
    logic [31:0] r_sdata;
    logic [31:0] r_rword;
    logic [31:0] r_load;
    logic [1:0]  r_fault;

    logic [1:0]  w_fault_in;
    logic        w_word_op;
    logic [31:0] w_load_ext;
    logic [31:0] w_merged;

    assign w_fault_in = fault_of(Op, Adress, MEM_WORDS);
    assign w_word_op  = (r_op == OP_LW);

    Alineador_bytes u_alineador (
        .i_op         (r_op),
        .i_lane       (r_addr[1:0]),
        .i_rdata      (Mem_read_data),
        .i_old_word   (r_rword),
        .i_store_data (r_sdata),
        .o_load       (w_load_ext),
        .o_merged     (w_merged)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next state and memory strobes; faults skip straight to DONE
    always_comb begin
        w_next         = r_state;
        MemRead        = 1'b0;
        MemWrite       = 1'b0;
        Mem_write_data = 32'b0;
        case (r_state)
            ST_IDLE: begin
                if (Req) w_next = (w_fault_in != FAULT_NONE) ? ST_DONE : ST_ACCESS;
            end
            ST_ACCESS: begin
                if (r_store && w_word_op) begin
                    MemWrite       = 1'b1;
                    Mem_write_data = r_sdata;
                    w_next         = ST_DONE;
                end else begin
                    MemRead = 1'b1;
                    w_next  = r_store ? ST_MERGE : ST_DONE;
                end
            end
            ST_MERGE: begin
                MemWrite       = 1'b1;
                Mem_write_data = w_merged;
                w_next         = ST_DONE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Request capture in IDLE, read data / load result capture in ACCESS
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= 7'b0;
            r_op    <= 3'b0;
            r_store <= 1'b0;
            r_sdata <= 32'b0;
            r_rword <= 32'b0;
            r_load  <= 32'b0;
            r_fault <= FAULT_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Req) begin
                        r_addr  <= Adress[6:0];
                        r_op    <= Op;
                        r_store <= Is_store;
                        r_sdata <= Store_data;
                        r_fault <= w_fault_in;
                    end
                end
                ST_ACCESS: begin
                    if (r_store) r_rword <= Mem_read_data;
                    else         r_load  <= w_load_ext;
                end
                default: ;
            endcase
        end
    end

    assign Busy       = (r_state != ST_IDLE);
    assign Done       = (r_state == ST_DONE);
    assign Fault      = Done ? r_fault : FAULT_NONE;
    assign Mem_adress = {27'b0, r_addr[6:2]};
    assign Load_data  = r_load;

endmodule

// File: tb/tb_unidad_acceso_memoria.sv
// Bench for unidad_acceso_memoria: directed cases plus randomized traffic
// scored against a byte-level reference model of the memory.
module tb_unidad_acceso_memoria;

    localparam int WORDS = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        Req;
    logic        Is_store;
    logic [2:0]  Op;
    logic [31:0] Adress;
    logic [31:0] Store_data;
    logic        Busy;
    logic        Done;
    logic [31:0] Load_data;
    logic [1:0]  Fault;
    logic [31:0] Mem_adress;
    logic [31:0] Mem_write_data;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Mem_read_data;

    typedef struct {
        logic [1:0]  fault;
        logic [31:0] load;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] idx;
        logic [31:0] wdata;
        int          acc;
    } exp_t;

    exp_t        q[$];
    exp_t        m_e;
    logic [31:0] mem [WORDS];
    logic [31:0] ref_mem [WORDS];
    logic [31:0] ref_load;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    bit          scramble = 1'b1;
    int          n_rd = 0;
    int          n_wr = 0;
    logic [31:0] seen_wdata;
    logic [1:0]  last_fault;

    unidad_acceso_memoria #(.MEM_WORDS(WORDS)) dut (
        .clk            (clk),
        .reset          (reset),
        .Req            (Req),
        .Is_store       (Is_store),
        .Op             (Op),
        .Adress         (Adress),
        .Store_data     (Store_data),
        .Busy           (Busy),
        .Done           (Done),
        .Load_data      (Load_data),
        .Fault          (Fault),
        .Mem_adress     (Mem_adress),
        .Mem_write_data (Mem_write_data),
        .MemWrite       (MemWrite),
        .MemRead        (MemRead),
        .Mem_read_data  (Mem_read_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory attached to the DUT
    assign Mem_read_data = mem[Mem_adress[4:0]];
    always @(posedge clk) if (MemWrite) mem[Mem_adress[4:0]] <= Mem_write_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference model: byte-granular view of memory, plain arithmetic
    task automatic predict(input logic [2:0] op, input logic st, input logic [31:0] a,
                           input logic [31:0] sd, output exp_t e);
        int          size;
        int          k;
        logic [63:0] val;
        logic [31:0] w;
        size = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
        e.nrd = 0; e.nwr = 0; e.idx = a / 4; e.wdata = 32'b0;
        if (!(op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))   e.fault = 2'b11;
        else if ((a % size) != 0)                         e.fault = 2'b01;
        else if ((a / 4) >= WORDS)                        e.fault = 2'b10;
        else                                              e.fault = 2'b00;
        if (e.fault != 2'b00) begin
            e.lat = 1;
        end else begin
            k = a % 4;
            w = ref_mem[a / 4];
            if (!st) begin
                val = ({32'b0, w} >> (8 * k)) % (64'd1 << (8 * size));
                if (op < 4 && size < 4 && val >= (64'd1 << (8 * size - 1)))
                    val = val + (64'd1 << 32) - (64'd1 << (8 * size));
                ref_load = val[31:0];
                e.nrd = 1; e.lat = 2;
            end else begin
                for (int b = 0; b < size; b++) w[8 * (k + b) +: 8] = sd[8 * b +: 8];
                ref_mem[a / 4] = w;
                e.wdata = w; e.nwr = 1;
                e.nrd = (size == 4) ? 0 : 1;
                e.lat = (size == 4) ? 2 : 3;
            end
        end
        e.load = ref_load;
    endtask

    task automatic garbage();
        Req = 1'($urandom); Is_store = 1'($urandom); Op = 3'($urandom);
        Adress = $urandom; Store_data = $urandom;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (Busy) begin
            if (scramble) garbage();
            @(negedge clk);
            g++;
            if (g > 20) begin
                checks++; errors++;
                $display("FAIL busy_timeout actual=%0d expected=<=20", g);
                $fatal(1, "DUT stuck busy");
            end
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic st, input logic [31:0] a,
                         input logic [31:0] sd);
        exp_t e;
        wait_idle();
        Req = 1'b1; Op = op; Is_store = st; Adress = a; Store_data = sd;
        predict(op, st, a, sd, e);
        e.acc = cyc + 1;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic finish_idle();
        wait_idle();
        Req = 1'b0;
        @(negedge clk);
    endtask

    task automatic preload(input int idx, input logic [31:0] v);
        mem[idx] <= v;
        ref_mem[idx] = v;
        @(negedge clk);
    endtask

    // Monitor: strobe legality and per-transaction completion checks
    always @(negedge clk) begin
        if (mon_en) begin
            if (MemRead && MemWrite) chk("strobe_overlap", 32'd1, 32'd0);
            if ((MemRead || MemWrite) && (!Busy || Done)) chk("strobe_idle_done", 32'd1, 32'd0);
            if (MemRead || MemWrite) begin
                if (q.size() == 0) chk("strobe_unexpected", 32'd1, 32'd0);
                else chk("mem_adress", Mem_adress, q[0].idx);
                if (MemRead) n_rd++;
                if (MemWrite) begin n_wr++; seen_wdata = Mem_write_data; end
            end
            if (Done) begin
                last_fault = Fault;
                if (q.size() == 0) begin
                    chk("done_unexpected", 32'd1, 32'd0);
                end else begin
                    m_e = q.pop_front();
                    chk("fault", 32'(Fault), 32'(m_e.fault));
                    chk("load_data", Load_data, m_e.load);
                    chk("latency", 32'(cyc + 1 - m_e.acc), 32'(m_e.lat));
                    chk("reads", 32'(n_rd), 32'(m_e.nrd));
                    chk("writes", 32'(n_wr), 32'(m_e.nwr));
                    if (m_e.nwr != 0) chk("write_data", seen_wdata, m_e.wdata);
                end
                n_rd = 0; n_wr = 0;
            end
        end
    end

    initial begin
        logic [31:0] v;
        logic [2:0]  op;
        logic [31:0] a;
        reset = 1'b1; Req = 1'b0; Is_store = 1'b0; Op = 3'b0; Adress = 32'b0; Store_data = 32'b0;
        ref_load = 32'b0;
        for (int i = 0; i < WORDS; i++) begin
            v = $urandom; mem[i] <= v; ref_mem[i] = v;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_fault", 32'(Fault), 32'd0);
        chk("rst_memread", 32'(MemRead), 32'd0);
        chk("rst_memwrite", 32'(MemWrite), 32'd0);
        chk("rst_mem_adress", Mem_adress, 32'd0);
        chk("rst_mem_wdata", Mem_write_data, 32'd0);
        chk("rst_load_data", Load_data, 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // LW, LB, LBU, SB, and the three fault causes
        preload(3, 32'hDEADBEEF);
        issue(3'b010, 1'b0, 32'h0000000C, 32'h0);
        finish_idle();
        chk("lw_value", Load_data, 32'hDEADBEEF);
        preload(3, 32'h12348056);
        issue(3'b000, 1'b0, 32'h0000000D, 32'h0);
        finish_idle();
        chk("lb_value", Load_data, 32'hFFFFFF80);
        issue(3'b100, 1'b0, 32'h0000000D, 32'h0);
        finish_idle();
        chk("lbu_value", Load_data, 32'h00000080);
        preload(1, 32'h11223344);
        issue(3'b000, 1'b1, 32'h00000006, 32'h000000AA);
        finish_idle();
        chk("sb_mem", mem[1], 32'h11AA3344);
        issue(3'b001, 1'b0, 32'h00000003, 32'h0);
        finish_idle();
        chk("lh_misaligned", 32'(last_fault), 32'd1);
        issue(3'b010, 1'b1, 32'h00000080, 32'h5555AAAA);
        finish_idle();
        chk("sw_range", 32'(last_fault), 32'd2);
        issue(3'b011, 1'b0, 32'h00000000, 32'h0);
        finish_idle();
        chk("op_illegal", 32'(last_fault), 32'd3);
        chk("fault_keeps_load", Load_data, 32'h00000080);

        // Reset during the MERGE cycle of a half store
        mon_en = 1'b0;
        preload(2, 32'hCAFEF00D);
        Req = 1'b1; Op = 3'b001; Is_store = 1'b1; Adress = 32'h0000000A; Store_data = 32'h00001234;
        @(negedge clk);
        Req = 1'b0;
        @(negedge clk);
        chk("sh_merge_strobe", 32'(MemWrite), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_memwrite", 32'(MemWrite), 32'd0);
        chk("abort_busy", 32'(Busy), 32'd0);
        @(negedge clk);
        chk("abort_mem", mem[2], 32'hCAFEF00D);
        chk("abort_load", Load_data, 32'd0);
        chk("abort_adress", Mem_adress, 32'd0);
        reset = 1'b0;
        ref_load = 32'b0;
        n_rd = 0; n_wr = 0;
        @(negedge clk);
        mon_en = 1'b1;

        // Req held high through the whole operation, then re-issued in IDLE
        scramble = 1'b0;
        issue(3'b010, 1'b0, 32'h00000008, 32'h0);
        issue(3'b101, 1'b1, 32'h0000000E, 32'h0000BEEF);
        issue(3'b001, 1'b0, 32'h0000000E, 32'h0);
        scramble = 1'b1;
        finish_idle();

        // Randomized traffic with input noise while busy
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) op = 3'($urandom_range(0, 7));
            else case ($urandom_range(0, 4))
                0: op = 3'b000;
                1: op = 3'b001;
                2: op = 3'b010;
                3: op = 3'b100;
                default: op = 3'b101;
            endcase
            a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 127));
            issue(op, 1'($urandom), a, $urandom);
            if ($urandom_range(0, 3) == 0) finish_idle();
        end
        finish_idle();
        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        for (int i = 0; i < WORDS; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
